// File: rtl/mc_store_ctrl_pkg.sv
// mc_store_ctrl_pkg: shared definitions for the microcode control-store controller.
//   - default word/address widths
//   - sequencing FSM state encoding
//   - helper to detect the last cycle of a timed phase
package mc_store_ctrl_pkg;

   localparam int unsigned DefWidth = 64;
   localparam int unsigned DefAddrW = 8;
   localparam int unsigned CntW     = 8;   // phase timer width, covers wait/pulse params

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWrSetup,
      StWrPulse,
      StWrHold,
      StVfy
   } state_e;

   // True when a phase of n cycles (timer started at 0) is in its final cycle.
   function automatic logic is_last(input logic [CntW-1:0] cnt, input int unsigned n);
      return cnt == CntW'(n - 1);
   endfunction

endpackage

// File: rtl/mc_store_ctrl_arb.sv
// mc_store_ctrl_arb: grant logic for the control store plus loader starvation counter.
// Fetch has priority unless the loader has waited STARVE_LIMIT cycles, then the loader wins.
// Ports:
//   clk, _reset           clock, synchronous active-low reset
//   fetch_req, ld_req     requests from microsequencer and loader
//   idle                  controller can accept a new access this cycle
//   grant_fetch, grant_ld one-hot grants (combinational)
module mc_store_ctrl_arb #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic _reset,
   input  logic fetch_req,
   input  logic ld_req,
   input  logic idle,
   output logic grant_fetch,
   output logic grant_ld
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_q;
   logic          at_limit;

   assign at_limit = (starve_q == SW'(STARVE_LIMIT));

   always_comb begin
      grant_ld    = idle & ld_req & (~fetch_req | at_limit);
      grant_fetch = idle & fetch_req & ~grant_ld;
   end

   // Counts every cycle the loader asks and is not granted, including busy cycles.
   always_ff @(posedge clk) begin
      if (!_reset) begin
         starve_q <= '0;
      end else if (grant_ld) begin
         starve_q <= '0;
      end else if (ld_req && !at_limit) begin
         starve_q <= starve_q + SW'(1);
      end
   end

endmodule

// File: rtl/mc_store_ctrl.sv
// mc_store_ctrl: sequences the microcode control store between the fetch port (priority)
// and the loader port. All strobes/address/data outputs are registered; acks are
// combinational from IDLE and the requests.
// Optional: MC_STORE_WRITE_VERIFY_EN adds a read-back verify phase after each write and a
// sticky verify_err flag; without it verify_err is tied 0.
// Ports:
//   clk, _reset                        clock, synchronous active-low reset
//   fetch_req/addr/ack/valid/data      microsequencer read port
//   ld_req/we/addr/wdata/ack/rvalid/rdata  loader read/write port
//   _ram_cs/_ram_oe/_ram_w             active-low store strobes
//   ram_addr/ram_wdata/ram_rdata       store address and data
//   busy                               FSM not idle
//   verify_err                         sticky write-verify mismatch
module mc_store_ctrl
   import mc_store_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH        = DefWidth,
   parameter int unsigned ADDR_W       = DefAddrW,
   parameter int unsigned RD_WAIT_CYC  = 1,
   parameter int unsigned WR_PULSE_CYC = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              _reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic              fetch_valid,
   output logic [WIDTH-1:0]  fetch_data,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WIDTH-1:0]  ld_wdata,
   output logic              ld_ack,
   output logic              ld_rvalid,
   output logic [WIDTH-1:0]  ld_rdata,
   output logic              _ram_cs,
   output logic              _ram_oe,
   output logic              _ram_w,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [WIDTH-1:0]  ram_wdata,
   input  logic [WIDTH-1:0]  ram_rdata,
   output logic              busy,
   output logic              verify_err
);

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic            ld_owner_q;   // current read belongs to the loader
   logic            idle;
   logic            grant_fetch;
   logic            grant_ld;

   assign idle      = (state_q == StIdle);
   assign busy      = ~idle;
   assign fetch_ack = grant_fetch;
   assign ld_ack    = grant_ld;

   mc_store_ctrl_arb #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .clk        (clk),
      ._reset     (_reset),
      .fetch_req  (fetch_req),
      .ld_req     (ld_req),
      .idle       (idle),
      .grant_fetch(grant_fetch),
      .grant_ld   (grant_ld)
   );

`ifdef MC_STORE_WRITE_VERIFY_EN
   logic verify_err_q;
   assign verify_err = verify_err_q;
`else
   assign verify_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!_reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         ld_owner_q  <= 1'b0;
         _ram_cs     <= 1'b1;
         _ram_oe     <= 1'b1;
         _ram_w      <= 1'b1;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         fetch_data  <= '0;
         ld_rdata    <= '0;
         fetch_valid <= 1'b0;
         ld_rvalid   <= 1'b0;
`ifdef MC_STORE_WRITE_VERIFY_EN
         verify_err_q <= 1'b0;
`endif
      end else begin
         fetch_valid <= 1'b0;
         ld_rvalid   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (grant_fetch || grant_ld) begin
                  ld_owner_q <= grant_ld;
                  cnt_q      <= '0;
                  _ram_cs    <= 1'b0;
                  ram_addr   <= grant_ld ? ld_addr : fetch_addr;
                  if (grant_ld && ld_we) begin
                     ram_wdata <= ld_wdata;
                     state_q   <= StWrSetup;
                  end else begin
                     _ram_oe <= 1'b0;
                     state_q <= StRd;
                  end
               end
            end
            StRd: begin
               if (is_last(cnt_q, RD_WAIT_CYC)) begin
                  state_q <= StIdle;
                  _ram_cs <= 1'b1;
                  _ram_oe <= 1'b1;
                  if (ld_owner_q) begin
                     ld_rdata  <= ram_rdata;
                     ld_rvalid <= 1'b1;
                  end else begin
                     fetch_data  <= ram_rdata;
                     fetch_valid <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StWrSetup: begin
               state_q <= StWrPulse;
               _ram_w  <= 1'b0;
               cnt_q   <= '0;
            end
            StWrPulse: begin
               if (is_last(cnt_q, WR_PULSE_CYC)) begin
                  state_q <= StWrHold;
                  _ram_w  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StWrHold: begin
`ifdef MC_STORE_WRITE_VERIFY_EN
               state_q <= StVfy;
               _ram_oe <= 1'b0;
               cnt_q   <= '0;
`else
               state_q <= StIdle;
               _ram_cs <= 1'b1;
`endif
            end
`ifdef MC_STORE_WRITE_VERIFY_EN
            StVfy: begin
               if (is_last(cnt_q, RD_WAIT_CYC)) begin
                  state_q <= StIdle;
                  _ram_cs <= 1'b1;
                  _ram_oe <= 1'b1;
                  if (ram_rdata != ram_wdata) verify_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
`endif
            default: begin
               state_q <= StIdle;
               _ram_cs <= 1'b1;
               _ram_oe <= 1'b1;
               _ram_w  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_store_ctrl.sv
// tb_mc_store_ctrl: directed-vector bench for mc_store_ctrl with a behavioural control store.
// Expected read data is queued when a request is acked; a monitor pops and compares on each
// valid pulse. Honours MC_STORE_WRITE_VERIFY_EN for the verify-phase checks.
module tb_mc_store_ctrl;

   localparam int unsigned WIDTH  = 64;
   localparam int unsigned ADDR_W = 8;

   logic              clk = 1'b0;
   logic              _reset;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ack;
   logic              fetch_valid;
   logic [WIDTH-1:0]  fetch_data;
   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [WIDTH-1:0]  ld_wdata;
   logic              ld_ack;
   logic              ld_rvalid;
   logic [WIDTH-1:0]  ld_rdata;
   logic              _ram_cs;
   logic              _ram_oe;
   logic              _ram_w;
   logic [ADDR_W-1:0] ram_addr;
   logic [WIDTH-1:0]  ram_wdata;
   logic [WIDTH-1:0]  ram_rdata;
   logic              busy;
   logic              verify_err;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] lq[$];

   logic [WIDTH-1:0] mem [256];
   logic             stuck_en;

   mc_store_ctrl #(
      .WIDTH       (WIDTH),
      .ADDR_W      (ADDR_W),
      .RD_WAIT_CYC (1),
      .WR_PULSE_CYC(2),
      .STARVE_LIMIT(4)
   ) dut (
      .clk        (clk),
      ._reset     (_reset),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_ack  (fetch_ack),
      .fetch_valid(fetch_valid),
      .fetch_data (fetch_data),
      .ld_req     (ld_req),
      .ld_we      (ld_we),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .ld_ack     (ld_ack),
      .ld_rvalid  (ld_rvalid),
      .ld_rdata   (ld_rdata),
      ._ram_cs    (_ram_cs),
      ._ram_oe    (_ram_oe),
      ._ram_w     (_ram_w),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .busy       (busy),
      .verify_err (verify_err)
   );

   always #5 clk = ~clk;

   // Behavioural store: asynchronous read when selected, write latched on falling _w.
   always_comb begin
      ram_rdata = '0;
      if (!_ram_cs && !_ram_oe) ram_rdata = mem[ram_addr];
      if (stuck_en) ram_rdata[0] = 1'b0;
   end

   always @(negedge _ram_w) begin
      if (!_ram_cs) mem[ram_addr] = ram_wdata;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (fetch_valid) begin
         checks++;
         if (fq.size() == 0) begin
            errors++;
            $display("FAIL fetch_valid_unexpected: got data %h expected no pulse", fetch_data);
         end else begin
            checks--;
            check("fetch_data", fetch_data, fq.pop_front());
         end
      end
      if (ld_rvalid) begin
         checks++;
         if (lq.size() == 0) begin
            errors++;
            $display("FAIL ld_rvalid_unexpected: got data %h expected no pulse", ld_rdata);
         end else begin
            checks--;
            check("ld_rdata", ld_rdata, lq.pop_front());
         end
      end
   end

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      check("wait_idle", done, 1'b1);
   endtask

   task automatic fetch_read(input logic [7:0] a, input logic [63:0] exp);
      bit got = 1'b0;
      @(posedge clk); #1;
      fetch_req  = 1'b1;
      fetch_addr = a;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (fetch_ack) got = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("fetch_ack_seen", got, 1'b1);
      if (got) fq.push_back(exp);
      @(posedge clk); #1;
      fetch_req = 1'b0;
      wait_idle();
   endtask

   task automatic ld_access(input logic we, input logic [7:0] a, input logic [63:0] d,
                            input logic [63:0] exp);
      bit got = 1'b0;
      @(posedge clk); #1;
      ld_req   = 1'b1;
      ld_we    = we;
      ld_addr  = a;
      ld_wdata = d;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (ld_ack) got = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("ld_ack_seen", got, 1'b1);
      if (got && !we) lq.push_back(exp);
      @(posedge clk); #1;
      ld_req = 1'b0;
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ld_cyc;
      int nf;
      int idx;
      int ack_c [3];

      _reset = 1'b0; stuck_en = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h11] = 64'hDEAD_BEEF_0000_0011;
      mem[0] = 64'h0000_0000_0000_0100;
      mem[1] = 64'h0000_0000_0000_0201;
      mem[2] = 64'h0000_0000_0000_0302;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cs", _ram_cs, 1'b1);
      check("rst_oe", _ram_oe, 1'b1);
      check("rst_w", _ram_w, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_addr", ram_addr, 64'h0);
      check("rst_fetch_data", fetch_data, 64'h0);
      check("rst_ld_rdata", ld_rdata, 64'h0);
      check("rst_verify_err", verify_err, 1'b0);
      @(posedge clk); #1;
      _reset = 1'b1;

      // Single fetch, cycle-exact.
      @(posedge clk); #1;
      fetch_req = 1'b1; fetch_addr = 8'h11;
      @(negedge clk);
      check("t1_c0_ack", fetch_ack, 1'b1);
      check("t1_c0_cs", _ram_cs, 1'b1);
      if (fetch_ack) fq.push_back(64'hDEAD_BEEF_0000_0011);
      @(posedge clk); #1;
      fetch_req = 1'b0;
      @(negedge clk);
      check("t1_c1_cs", _ram_cs, 1'b0);
      check("t1_c1_oe", _ram_oe, 1'b0);
      check("t1_c1_w", _ram_w, 1'b1);
      check("t1_c1_addr", ram_addr, 64'h11);
      check("t1_c1_busy", busy, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_c2_valid", fetch_valid, 1'b1);
      check("t1_c2_busy", busy, 1'b0);
      check("t1_c2_cs", _ram_cs, 1'b1);

      // Loader write, cycle-exact strobe timing.
      @(posedge clk); #1;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h05; ld_wdata = 64'hA5A5;
      @(negedge clk);
      check("t2_c0_ld_ack", ld_ack, 1'b1);
      check("t2_c0_fetch_ack", fetch_ack, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         ld_req = 1'b0;
         @(negedge clk);
         check($sformatf("t2_c%0d_w", c), _ram_w, (c == 2 || c == 3) ? 1'b0 : 1'b1);
         check($sformatf("t2_c%0d_cs", c), _ram_cs, (c == 5) ? 1'b1 : 1'b0);
         check($sformatf("t2_c%0d_oe", c), _ram_oe, 1'b1);
         check($sformatf("t2_c%0d_busy", c), busy, (c == 5) ? 1'b0 : 1'b1);
      end
      fetch_read(8'h05, 64'hA5A5);

      // Contention: fetch held, loader read waits until starve counter hits 4.
      ld_cyc = -1;
      nf = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            fetch_req = 1'b1; fetch_addr = 8'h05;
            ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h11;
         end
         if (ld_cyc >= 0) ld_req = 1'b0;
         @(negedge clk);
         check("t3_ack_exclusive", fetch_ack & ld_ack, 1'b0);
         if (fetch_ack) begin
            nf++;
            fq.push_back(64'hA5A5);
         end
         if (ld_ack) begin
            ld_cyc = c;
            lq.push_back(64'hDEAD_BEEF_0000_0011);
         end
      end
      @(posedge clk); #1;
      fetch_req = 1'b0;
      ld_req = 1'b0;
      check("t3_ld_ack_cycle", 64'(ld_cyc), 64'd4);
      check("t3_fetch_count", 64'(nf), 64'd4);
      wait_idle();

      // Reset during the write pulse.
      @(posedge clk); #1;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 64'h1234;
      @(negedge clk);
      check("t4_ack", ld_ack, 1'b1);
      @(posedge clk); #1;
      ld_req = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_w_low", _ram_w, 1'b0);
      _reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_cs", _ram_cs, 1'b1);
      check("t4_oe", _ram_oe, 1'b1);
      check("t4_w", _ram_w, 1'b1);
      check("t4_busy", busy, 1'b0);
      check("t4_valids", {fetch_valid, ld_rvalid}, 2'b00);
      check("t4_wdata", ram_wdata, 64'h0);
      @(posedge clk); #1;
      _reset = 1'b1;
      fetch_read(8'h20, 64'h1234);

      // Back-to-back fetches of addresses 0,1,2.
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         fetch_req  = (idx < 3);
         fetch_addr = 8'(idx);
         @(negedge clk);
         if (fetch_ack && idx < 3) begin
            fq.push_back(64'h100 + 64'(idx) * 64'h101);
            ack_c[idx] = c;
            idx++;
         end
      end
      check("t5_count", 64'(idx), 64'd3);
      check("t5_ack0", 64'(ack_c[0]), 64'd0);
      check("t5_ack1", 64'(ack_c[1]), 64'd2);
      check("t5_ack2", 64'(ack_c[2]), 64'd4);
      @(posedge clk); #1;
      fetch_req = 1'b0;
      wait_idle();

`ifdef MC_STORE_WRITE_VERIFY_EN
      ld_access(1'b1, 8'h31, 64'h0F, 64'h0);
      check("t6_good_write", verify_err, 1'b0);
      stuck_en = 1'b1;
      ld_access(1'b1, 8'h32, 64'h0F, 64'h0);
      stuck_en = 1'b0;
      check("t6_bad_write", verify_err, 1'b1);
      repeat (3) @(negedge clk);
      check("t6_sticky", verify_err, 1'b1);
      ld_access(1'b0, 8'h32, 64'h0, 64'h0F);
      check("t6_sticky_after_read", verify_err, 1'b1);
      @(posedge clk); #1;
      _reset = 1'b0;
      @(posedge clk); #1;
      _reset = 1'b1;
      @(negedge clk);
      check("t6_cleared", verify_err, 1'b0);
`else
      ld_access(1'b1, 8'h31, 64'h0F, 64'h0);
      ld_access(1'b0, 8'h31, 64'h0, 64'h0F);
      check("t6_verify_tied", verify_err, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("fq_drained", 64'(fq.size()), 64'd0);
      check("lq_drained", 64'(lq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
